// File: rtl/control_unit_fsm.sv
// =============================================================================
// Module   : control_unit_fsm
// Brief    : Hardwired Moore control sequencer for the single-bus CPU datapath.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module control_unit_fsm #(
    parameter int         MEM_WAIT = 0,
    parameter logic [4:0] OP_ADD   = 5'b00011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON_output,
    input  logic        stop,
    output logic        PCout,
    output logic        ZLowout,
    output logic        ZHighout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        MAR_enable,
    output logic        PC_enable,
    output logic        IncPC,
    output logic        MDR_enable,
    output logic        IR_enable,
    output logic        Y_enable,
    output logic        Z_low_enable,
    output logic        Z_high_enable,
    output logic        HI_enable,
    output logic        LO_enable,
    output logic        OutPort_enable,
    output logic        Read,
    output logic        Write,
    output logic        GRA,
    output logic        GRB,
    output logic        GRC,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        CON_in,
    output logic [4:0]  operation,
    output logic        Run,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4   = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
    } state_t;

    localparam logic [4:0] c_LD   = 5'b00000;
    localparam logic [4:0] c_LDI  = 5'b00001;
    localparam logic [4:0] c_ST   = 5'b00010;
    localparam logic [4:0] c_BR   = 5'b10011;
    localparam logic [4:0] c_JR   = 5'b10100;
    localparam logic [4:0] c_IN   = 5'b10110;
    localparam logic [4:0] c_OUT  = 5'b10111;
    localparam logic [4:0] c_MFHI = 5'b11000;
    localparam logic [4:0] c_MFLO = 5'b11001;
    localparam logic [4:0] c_HALT = 5'b11011;

    state_t     r_state;
    logic [2:0] r_wait;
    logic [4:0] w_op;
    logic       w_undef;
    logic       w_hold;
    logic       w_write;
    state_t     w_last;
    logic       w_unused_ir;

    assign w_op        = IR[31:27];
    assign w_unused_ir = ^IR[26:0];
    assign w_undef     = (w_op == 5'b10101) || (w_op >= 5'b11100);
    assign w_hold      = ((r_state == S_T1) || (r_state == S_T6 && w_op == c_LD))
                         && (r_wait != 3'(MEM_WAIT));

    // Final execute step of the current opcode; T2 means fetch-only.
    always_comb begin
        w_last = S_T2;
        if (w_op == c_LD || w_op == c_ST)               w_last = S_T7;
        else if (w_op inside {[5'd1:5'd14]})            w_last = S_T5;
        else if (w_op == 5'd15 || w_op == 5'd16 || w_op == c_BR) w_last = S_T6;
        else if (w_op == 5'd17 || w_op == 5'd18)        w_last = S_T4;
        else if (w_op inside {c_JR, c_IN, c_OUT, c_MFHI, c_MFLO}) w_last = S_T3;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_wait  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: if (!stop) r_state <= S_T0;
                S_HALT: r_state <= S_HALT;
                default: begin
                    if (w_hold) begin
                        r_wait <= r_wait + 3'd1;
                    end else begin
                        r_wait <= 3'd0;
                        if (r_state == S_T2 && w_op == c_HALT)
                            r_state <= S_HALT;
                        else if (r_state == w_last)
                            r_state <= stop ? S_IDLE : S_T0;
                        else
                            r_state <= state_t'(r_state + 4'd1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        {PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout} = '0;
        {MAR_enable, PC_enable, IncPC, MDR_enable, IR_enable, Y_enable} = '0;
        {Z_low_enable, Z_high_enable, HI_enable, LO_enable, OutPort_enable} = '0;
        {Read, w_write, GRA, GRB, GRC, Rin, Rout, BAout, CON_in} = '0;
        operation = 5'd0;
        illegal   = 1'b0;
        Run       = (r_state != S_IDLE) && (r_state != S_HALT);
        case (r_state)
            S_T0: {PCout, MAR_enable, PC_enable, IncPC} = '1;
            S_T1: {Read, MDR_enable} = '1;
            S_T2: begin
                {MDRout, IR_enable} = '1;
                illegal = w_undef;
            end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (w_op == c_LD || w_op == c_LDI || w_op == c_ST) begin
                    case (r_state)
                        S_T3: {GRB, BAout, Y_enable} = '1;
                        S_T4: begin
                            {Cout, Z_low_enable} = '1;
                            operation = OP_ADD;
                        end
                        S_T5: if (w_op == c_LDI) {ZLowout, GRA, Rin} = '1;
                              else               {ZLowout, MAR_enable} = '1;
                        S_T6: if (w_op == c_LD)      {Read, MDR_enable} = '1;
                              else if (w_op == c_ST) {GRA, Rout, MDR_enable} = '1;
                        S_T7: if (w_op == c_LD)      {MDRout, GRA, Rin} = '1;
                              else if (w_op == c_ST) w_write = 1'b1;
                        default: ;
                    endcase
                end else if (w_op inside {[5'd3:5'd14]}) begin
                    // Immediate forms take operand B from the C-sign-extend path.
                    case (r_state)
                        S_T3: {GRB, Rout, Y_enable} = '1;
                        S_T4: begin
                            if (w_op >= 5'd12) Cout = 1'b1;
                            else               {GRC, Rout} = '1;
                            Z_low_enable = 1'b1;
                            operation    = w_op;
                        end
                        S_T5: {ZLowout, GRA, Rin} = '1;
                        default: ;
                    endcase
                end else if (w_op == 5'd15 || w_op == 5'd16) begin
                    case (r_state)
                        S_T3: {GRA, Rout, Y_enable} = '1;
                        S_T4: begin
                            {GRB, Rout, Z_low_enable, Z_high_enable} = '1;
                            operation = w_op;
                        end
                        S_T5: {ZLowout, LO_enable} = '1;
                        S_T6: {ZHighout, HI_enable} = '1;
                        default: ;
                    endcase
                end else if (w_op == 5'd17 || w_op == 5'd18) begin
                    case (r_state)
                        S_T3: begin
                            {GRB, Rout, Z_low_enable} = '1;
                            operation = w_op;
                        end
                        S_T4: {ZLowout, GRA, Rin} = '1;
                        default: ;
                    endcase
                end else if (w_op == c_BR) begin
                    case (r_state)
                        S_T3: {GRA, Rout, CON_in} = '1;
                        S_T4: {PCout, Y_enable} = '1;
                        S_T5: begin
                            {Cout, Z_low_enable} = '1;
                            operation = OP_ADD;
                        end
                        S_T6: begin
                            ZLowout   = 1'b1;
                            PC_enable = CON_output;
                        end
                        default: ;
                    endcase
                end else if (r_state == S_T3) begin
                    case (w_op)
                        c_JR:    {GRA, Rout, PC_enable} = '1;
                        c_IN:    {InPortout, GRA, Rin} = '1;
                        c_OUT:   {GRA, Rout, OutPort_enable} = '1;
                        c_MFHI:  {HIout, GRA, Rin} = '1;
                        c_MFLO:  {LOout, GRA, Rin} = '1;
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Memory writes are suppressed the instant clear rises, ahead of the state reset.
    assign Write = w_write & ~clear;

endmodule

`default_nettype wire

// File: tb/tb_control_unit_fsm.sv
// =============================================================================
// Module   : tb_control_unit_fsm
// Brief    : Scoreboard testbench for control_unit_fsm (MEM_WAIT=0 and MEM_WAIT=2).
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_control_unit_fsm;

    // Output vector layout: [34:27] bus sources, [26:16] enables, [15:14] Read/Write,
    // [13:7] GRA..CON_in, [6:2] operation, [1] Run, [0] illegal.
    localparam logic [34:0] M_PCOUT  = 35'd1 << 34;
    localparam logic [34:0] M_ZLO    = 35'd1 << 33;
    localparam logic [34:0] M_ZHI    = 35'd1 << 32;
    localparam logic [34:0] M_MDROUT = 35'd1 << 31;
    localparam logic [34:0] M_HIOUT  = 35'd1 << 30;
    localparam logic [34:0] M_LOOUT  = 35'd1 << 29;
    localparam logic [34:0] M_INPORT = 35'd1 << 28;
    localparam logic [34:0] M_COUT   = 35'd1 << 27;
    localparam logic [34:0] M_MAR    = 35'd1 << 26;
    localparam logic [34:0] M_PCEN   = 35'd1 << 25;
    localparam logic [34:0] M_INCPC  = 35'd1 << 24;
    localparam logic [34:0] M_MDREN  = 35'd1 << 23;
    localparam logic [34:0] M_IREN   = 35'd1 << 22;
    localparam logic [34:0] M_YEN    = 35'd1 << 21;
    localparam logic [34:0] M_ZLEN   = 35'd1 << 20;
    localparam logic [34:0] M_ZHEN   = 35'd1 << 19;
    localparam logic [34:0] M_HIEN   = 35'd1 << 18;
    localparam logic [34:0] M_LOEN   = 35'd1 << 17;
    localparam logic [34:0] M_OUTEN  = 35'd1 << 16;
    localparam logic [34:0] M_READ   = 35'd1 << 15;
    localparam logic [34:0] M_WRITE  = 35'd1 << 14;
    localparam logic [34:0] M_GRA    = 35'd1 << 13;
    localparam logic [34:0] M_GRB    = 35'd1 << 12;
    localparam logic [34:0] M_GRC    = 35'd1 << 11;
    localparam logic [34:0] M_RIN    = 35'd1 << 10;
    localparam logic [34:0] M_ROUT   = 35'd1 << 9;
    localparam logic [34:0] M_BAOUT  = 35'd1 << 8;
    localparam logic [34:0] M_CONIN  = 35'd1 << 7;
    localparam logic [34:0] M_RUN    = 35'd1 << 1;
    localparam logic [34:0] M_ILL    = 35'd1;
    localparam logic [4:0]  ALU_ADD  = 5'b00011;

    logic        clock;
    logic        clear;
    logic [31:0] IR;
    logic        CON_output;
    logic        stop;
    wire  [34:0] w_o0;
    wire  [34:0] w_o2;

    logic [34:0] q[$];
    int          n_total;
    int          n_bad;

    control_unit_fsm #(.MEM_WAIT(0), .OP_ADD(5'b00011)) u_dut0 (
        .clock(clock), .clear(clear), .IR(IR), .CON_output(CON_output), .stop(stop),
        .PCout(w_o0[34]), .ZLowout(w_o0[33]), .ZHighout(w_o0[32]), .MDRout(w_o0[31]),
        .HIout(w_o0[30]), .LOout(w_o0[29]), .InPortout(w_o0[28]), .Cout(w_o0[27]),
        .MAR_enable(w_o0[26]), .PC_enable(w_o0[25]), .IncPC(w_o0[24]),
        .MDR_enable(w_o0[23]), .IR_enable(w_o0[22]), .Y_enable(w_o0[21]),
        .Z_low_enable(w_o0[20]), .Z_high_enable(w_o0[19]), .HI_enable(w_o0[18]),
        .LO_enable(w_o0[17]), .OutPort_enable(w_o0[16]), .Read(w_o0[15]),
        .Write(w_o0[14]), .GRA(w_o0[13]), .GRB(w_o0[12]), .GRC(w_o0[11]),
        .Rin(w_o0[10]), .Rout(w_o0[9]), .BAout(w_o0[8]), .CON_in(w_o0[7]),
        .operation(w_o0[6:2]), .Run(w_o0[1]), .illegal(w_o0[0])
    );

    control_unit_fsm #(.MEM_WAIT(2), .OP_ADD(5'b00011)) u_dut2 (
        .clock(clock), .clear(clear), .IR(IR), .CON_output(CON_output), .stop(stop),
        .PCout(w_o2[34]), .ZLowout(w_o2[33]), .ZHighout(w_o2[32]), .MDRout(w_o2[31]),
        .HIout(w_o2[30]), .LOout(w_o2[29]), .InPortout(w_o2[28]), .Cout(w_o2[27]),
        .MAR_enable(w_o2[26]), .PC_enable(w_o2[25]), .IncPC(w_o2[24]),
        .MDR_enable(w_o2[23]), .IR_enable(w_o2[22]), .Y_enable(w_o2[21]),
        .Z_low_enable(w_o2[20]), .Z_high_enable(w_o2[19]), .HI_enable(w_o2[18]),
        .LO_enable(w_o2[17]), .OutPort_enable(w_o2[16]), .Read(w_o2[15]),
        .Write(w_o2[14]), .GRA(w_o2[13]), .GRB(w_o2[12]), .GRC(w_o2[11]),
        .Rin(w_o2[10]), .Rout(w_o2[9]), .BAout(w_o2[8]), .CON_in(w_o2[7]),
        .operation(w_o2[6:2]), .Run(w_o2[1]), .illegal(w_o2[0])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%09h exp=%09h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] stp(input logic [34:0] m, input logic [4:0] alu);
        return m | (35'(alu) << 2) | M_RUN;
    endfunction

    function automatic logic [34:0] t0v();
        return stp(M_PCOUT | M_MAR | M_PCEN | M_INCPC, 5'd0);
    endfunction

    // Expected per-cycle outputs of one instruction, fetch through last execute step.
    task automatic push_instr(input logic [4:0] op, input int mw, input logic con);
        logic undef;
        undef = (op == 5'd21) || (op >= 5'd28);
        q.push_back(t0v());
        repeat (mw + 1) q.push_back(stp(M_READ | M_MDREN, 5'd0));
        q.push_back(stp(M_MDROUT | M_IREN | (undef ? M_ILL : 35'd0), 5'd0));
        if (op <= 5'd2) begin
            q.push_back(stp(M_GRB | M_BAOUT | M_YEN, 5'd0));
            q.push_back(stp(M_COUT | M_ZLEN, ALU_ADD));
            if (op == 5'd1) begin
                q.push_back(stp(M_ZLO | M_GRA | M_RIN, 5'd0));
            end else begin
                q.push_back(stp(M_ZLO | M_MAR, 5'd0));
                if (op == 5'd0) begin
                    repeat (mw + 1) q.push_back(stp(M_READ | M_MDREN, 5'd0));
                    q.push_back(stp(M_MDROUT | M_GRA | M_RIN, 5'd0));
                end else begin
                    q.push_back(stp(M_GRA | M_ROUT | M_MDREN, 5'd0));
                    q.push_back(stp(M_WRITE, 5'd0));
                end
            end
        end else if (op <= 5'd14) begin
            q.push_back(stp(M_GRB | M_ROUT | M_YEN, 5'd0));
            q.push_back(stp(((op >= 5'd12) ? M_COUT : (M_GRC | M_ROUT)) | M_ZLEN, op));
            q.push_back(stp(M_ZLO | M_GRA | M_RIN, 5'd0));
        end else if (op <= 5'd16) begin
            q.push_back(stp(M_GRA | M_ROUT | M_YEN, 5'd0));
            q.push_back(stp(M_GRB | M_ROUT | M_ZLEN | M_ZHEN, op));
            q.push_back(stp(M_ZLO | M_LOEN, 5'd0));
            q.push_back(stp(M_ZHI | M_HIEN, 5'd0));
        end else if (op <= 5'd18) begin
            q.push_back(stp(M_GRB | M_ROUT | M_ZLEN, op));
            q.push_back(stp(M_ZLO | M_GRA | M_RIN, 5'd0));
        end else begin
            case (op)
                5'd19: begin
                    q.push_back(stp(M_GRA | M_ROUT | M_CONIN, 5'd0));
                    q.push_back(stp(M_PCOUT | M_YEN, 5'd0));
                    q.push_back(stp(M_COUT | M_ZLEN, ALU_ADD));
                    q.push_back(stp(M_ZLO | (con ? M_PCEN : 35'd0), 5'd0));
                end
                5'd20: q.push_back(stp(M_GRA | M_ROUT | M_PCEN, 5'd0));
                5'd22: q.push_back(stp(M_INPORT | M_GRA | M_RIN, 5'd0));
                5'd23: q.push_back(stp(M_GRA | M_ROUT | M_OUTEN, 5'd0));
                5'd24: q.push_back(stp(M_HIOUT | M_GRA | M_RIN, 5'd0));
                5'd25: q.push_back(stp(M_LOOUT | M_GRA | M_RIN, 5'd0));
                default: ;
            endcase
        end
    endtask

    // Reset, release, then compare one DUT against the queue cycle by cycle.
    task automatic run_seq(input string name, input int sel, input logic stop_after_first);
        int idx;
        clear = 1'b1;
        stop  = 1'b0;
        @(negedge clock);
        check($sformatf("%s_rst", name), (sel == 2) ? w_o2 : w_o0, q.pop_front());
        clear = 1'b0;
        idx = 0;
        while (q.size() > 0) begin
            @(negedge clock);
            check($sformatf("%s_c%0d", name, idx), (sel == 2) ? w_o2 : w_o0, q.pop_front());
            if (idx == 0 && stop_after_first) stop = 1'b1;
            idx++;
        end
    endtask

    initial begin
        bit seen;
        n_total    = 0;
        n_bad      = 0;
        clear      = 1'b1;
        stop       = 1'b0;
        CON_output = 1'b0;
        IR         = 32'd0;

        IR = 32'h18918000;
        q.push_back(35'd0);
        push_instr(5'd3, 0, 1'b0);
        q.push_back(t0v());
        run_seq("add", 0, 1'b0);

        IR = {5'd27, 27'd0};
        q.push_back(35'd0);
        push_instr(5'd27, 0, 1'b0);
        repeat (20) q.push_back(35'd0);
        run_seq("halt", 0, 1'b0);

        IR = {5'd31, 27'h5A5A5A5};
        q.push_back(35'd0);
        push_instr(5'd31, 0, 1'b0);
        repeat (3) q.push_back(35'd0);
        run_seq("ill_stop", 0, 1'b1);

        for (int cfg = 0; cfg < 2; cfg++) begin
            for (int op = 0; op < 32; op++) begin
                IR         = {5'(op), 27'($urandom)};
                CON_output = (cfg == 0);
                q.push_back(35'd0);
                push_instr(5'(op), (cfg == 0) ? 0 : 2, CON_output);
                if (op == 27) repeat (3) q.push_back(35'd0);
                else q.push_back(t0v());
                run_seq($sformatf("mw%0d_op%0d", cfg * 2, op), cfg * 2, 1'b0);
            end
        end

        // Clear raised while st is writing must drop Write at once.
        IR    = {5'd2, 27'd0};
        clear = 1'b1;
        stop  = 1'b0;
        @(negedge clock);
        clear = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            seen = w_o0[14];
        end
        check("st_write_seen", {34'd0, seen}, 35'd1);
        clear = 1'b1;
        #1;
        check("clr_kills_write", w_o0, 35'd0);
        @(negedge clock);
        check("clr_idle", w_o0, 35'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
